// File: rtl/am_query_streamer.sv
// Associative-memory query streamer: streams query/class chunks to an external tree adder and tracks the argmax class.
// Optional AM_REJECT_EN adds a reject_threshold input and a registered rejected flag.
module am_query_streamer #(
  parameter int DIMS_PER_CC = 500,
  parameter int NUM_CHUNKS  = 10,
  parameter int NUM_CLASSES = 26
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  output logic                                      busy,
  output logic                                      done,
  output logic [$clog2(NUM_CHUNKS)-1:0]             q_rd_addr,
  input  logic [DIMS_PER_CC-1:0]                    q_rd_data,
  output logic [$clog2(NUM_CLASSES*NUM_CHUNKS)-1:0] cl_rd_addr,
  input  logic [DIMS_PER_CC-1:0]                    cl_rd_data,
  output logic                                      rd_en,
  output logic [DIMS_PER_CC-1:0]                    and_array_out,
  output logic                                      comparing_query_hv_with_class_hv,
  output logic                                      inferring_class,
  input  logic [12:0]                               similarity_value,
  output logic [$clog2(NUM_CLASSES)-1:0]            predicted_class,
  output logic [12:0]                               best_similarity
`ifdef AM_REJECT_EN
  ,
  input  logic [12:0]                               reject_threshold,
  output logic                                      rejected
`endif
);

  localparam int QAW  = $clog2(NUM_CHUNKS);
  localparam int CAW  = $clog2(NUM_CLASSES*NUM_CHUNKS);
  localparam int CLW  = $clog2(NUM_CLASSES);
  localparam int CNTW = $clog2(NUM_CHUNKS+1);

  typedef enum logic [1:0] {IDLE, FETCH, COMPARE, DONE} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [CNTW-1:0] r_chunk;
  logic [CLW-1:0]  r_class;
  logic [CAW-1:0]  r_class_base;
  logic [CLW-1:0]  r_pred;
  logic [12:0]     r_best;
  logic            w_issue;
  logic            w_last_class;

  // The chunk counter runs one past the last chunk: that extra FETCH cycle drains the final read.
  assign w_issue      = (r_state == FETCH) && (r_chunk < CNTW'(NUM_CHUNKS));
  assign w_last_class = (r_class == CLW'(NUM_CLASSES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state                     = r_state;
    busy                             = 1'b0;
    done                             = 1'b0;
    rd_en                            = 1'b0;
    q_rd_addr                        = '0;
    cl_rd_addr                       = '0;
    comparing_query_hv_with_class_hv = 1'b0;
    inferring_class                  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next_state = FETCH;
      end
      FETCH: begin
        busy                             = 1'b1;
        rd_en                            = w_issue;
        comparing_query_hv_with_class_hv = (r_chunk != '0);
        if (w_issue) begin
          q_rd_addr  = QAW'(r_chunk);
          cl_rd_addr = r_class_base + CAW'(r_chunk);
        end else begin
          w_next_state = COMPARE;
        end
      end
      COMPARE: begin
        busy            = 1'b1;
        inferring_class = 1'b1;
        w_next_state    = w_last_class ? DONE : FETCH;
      end
      DONE: begin
        done         = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign and_array_out = comparing_query_hv_with_class_hv ? (q_rd_data & cl_rd_data) : '0;

  // Class base address advances by NUM_CHUNKS per class, avoiding a multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chunk      <= '0;
      r_class      <= '0;
      r_class_base <= '0;
      r_pred       <= '0;
      r_best       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_chunk      <= '0;
            r_class      <= '0;
            r_class_base <= '0;
          end
        end
        FETCH: begin
          if (w_issue) r_chunk <= r_chunk + CNTW'(1);
        end
        COMPARE: begin
          if ((r_class == '0) || (similarity_value > r_best)) begin
            r_best <= similarity_value;
            r_pred <= r_class;
          end
          if (!w_last_class) begin
            r_class      <= r_class + CLW'(1);
            r_class_base <= r_class_base + CAW'(NUM_CHUNKS);
            r_chunk      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign predicted_class = r_pred;
  assign best_similarity = r_best;

`ifdef AM_REJECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rejected <= 1'b0;
    end else if (r_state == DONE) begin
      rejected <= (r_best < reject_threshold);
    end
  end
`endif

endmodule

// File: tb/tb_am_query_streamer.sv
// Directed self-checking bench for am_query_streamer with a registered memory model and a tree-adder model.
module tb_am_query_streamer;

   localparam int DIMS    = 16;
   localparam int CHUNKS  = 10;
   localparam int CLASSES = 4;
   localparam int QAW     = $clog2(CHUNKS);
   localparam int CAW     = $clog2(CLASSES*CHUNKS);
   localparam int CLW     = $clog2(CLASSES);
   localparam int RUN_CYCLES = CLASSES*(CHUNKS+2)+1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic            busy;
   logic            done;
   logic [QAW-1:0]  q_rd_addr;
   logic [DIMS-1:0] q_rd_data = '0;
   logic [CAW-1:0]  cl_rd_addr;
   logic [DIMS-1:0] cl_rd_data = '0;
   logic            rd_en;
   logic [DIMS-1:0] and_array_out;
   logic            comparing;
   logic            inferring_class;
   logic [12:0]     similarity_value;
   logic [CLW-1:0]  predicted_class;
   logic [12:0]     best_similarity;
`ifdef AM_REJECT_EN
   logic [12:0]     rejectThreshold = 13'd1;
   logic            rejected;
`endif

   am_query_streamer #(
      .DIMS_PER_CC(DIMS),
      .NUM_CHUNKS (CHUNKS),
      .NUM_CLASSES(CLASSES)
   ) dut (
      .clk                             (clk),
      .rst                             (rst),
      .start                           (start),
      .busy                            (busy),
      .done                            (done),
      .q_rd_addr                       (q_rd_addr),
      .q_rd_data                       (q_rd_data),
      .cl_rd_addr                      (cl_rd_addr),
      .cl_rd_data                      (cl_rd_data),
      .rd_en                           (rd_en),
      .and_array_out                   (and_array_out),
      .comparing_query_hv_with_class_hv(comparing),
      .inferring_class                 (inferring_class),
      .similarity_value                (similarity_value),
      .predicted_class                 (predicted_class),
      .best_similarity                 (best_similarity)
`ifdef AM_REJECT_EN
      ,
      .reject_threshold                (rejectThreshold),
      .rejected                        (rejected)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Query and class memories with one cycle of read latency.
   logic [DIMS-1:0] qMem  [CHUNKS];
   logic [DIMS-1:0] clMem [CLASSES*CHUNKS];
   always @(posedge clk) begin
      if (rd_en) begin
         q_rd_data  <= qMem[q_rd_addr];
         cl_rd_data <= clMem[cl_rd_addr];
      end
   end

   // Tree adder: accumulates while comparing, holds while inferring, clears otherwise.
   logic [12:0] accReg = '0;
   always @(posedge clk) begin
      if (rst) accReg <= '0;
      else if (comparing) accReg <= accReg + 13'($countones(and_array_out));
      else if (!inferring_class) accReg <= '0;
   end
   assign similarity_value = accReg;

   // Protocol monitor sampling mid-cycle on the falling edge.
   int compCnt = 0, infCnt = 0, clearCnt = 0, doneCnt = 0, busyCnt = 0, andViol = 0, runLen = 0;
   int runQ[$];
   int addrQ[$];
   int qAddrQ[$];
   always @(negedge clk) begin
      if (comparing) compCnt <= compCnt + 1;
      if (inferring_class) infCnt <= infCnt + 1;
      if (rd_en && !comparing) clearCnt <= clearCnt + 1;
      if (done) doneCnt <= doneCnt + 1;
      if (busy) busyCnt <= busyCnt + 1;
      if (!comparing && and_array_out != '0) andViol <= andViol + 1;
      if (rst) begin
         runLen <= 0;
      end else if (inferring_class) begin
         runQ.push_back(runLen);
         runLen <= 0;
      end else if (comparing) begin
         runLen <= runLen + 1;
      end
      if (rd_en) begin
         addrQ.push_back(int'(cl_rd_addr));
         qAddrQ.push_back(int'(q_rd_addr));
      end
   end

   int passCnt = 0;
   int checkCnt = 0;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCnt++;
      if (observed == expected) passCnt++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
   endtask

   // Fill query memory with one chunk pattern and each class with its own chunk pattern.
   task automatic loadVectors(input logic [DIMS-1:0] q, input logic [DIMS-1:0] c0,
                              input logic [DIMS-1:0] c1, input logic [DIMS-1:0] c2,
                              input logic [DIMS-1:0] c3);
      for (int k = 0; k < CHUNKS; k++) begin
         qMem[k]           = q;
         clMem[0*CHUNKS+k] = c0;
         clMem[1*CHUNKS+k] = c1;
         clMem[2*CHUNKS+k] = c2;
         clMem[3*CHUNKS+k] = c3;
      end
   endtask

   // Pulse start, then step cycle by cycle until done, optionally re-pulsing start or raising rst.
   task automatic applyStimulus(input int pulseAt, input int rstAt, output int doneCyc);
      int cyc;
      doneCyc = -1;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      cyc = 1;
      while (cyc <= 4*RUN_CYCLES) begin
         if (done) begin
            doneCyc = cyc;
            break;
         end
         if (cyc == rstAt) begin
            rst = 1'b1;
            break;
         end
         start = (cyc == pulseAt);
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, " busy"}, int'(busy), 0);
      checkOutput({tag, " done"}, int'(done), 0);
      checkOutput({tag, " rd_en"}, int'(rd_en), 0);
      checkOutput({tag, " q_rd_addr"}, int'(q_rd_addr), 0);
      checkOutput({tag, " cl_rd_addr"}, int'(cl_rd_addr), 0);
      checkOutput({tag, " and_array_out"}, int'(and_array_out), 0);
      checkOutput({tag, " comparing"}, int'(comparing), 0);
      checkOutput({tag, " inferring"}, int'(inferring_class), 0);
      checkOutput({tag, " predicted_class"}, int'(predicted_class), 0);
      checkOutput({tag, " best_similarity"}, int'(best_similarity), 0);
   endtask

   // One full inference with result, latency, handshake and per-class activity checks.
   task automatic runAndCheck(input string name, input int expPred, input int expBest,
                              input int expRej, input int pulseAt);
      int c0, i0, cl0, d0, b0, a0, r0, ad0, doneCyc, errs, qErrs;
      c0 = compCnt; i0 = infCnt; cl0 = clearCnt; d0 = doneCnt; b0 = busyCnt; a0 = andViol;
      r0 = runQ.size(); ad0 = addrQ.size();
      applyStimulus(pulseAt, -1, doneCyc);
      checkOutput({name, " done cycle"}, doneCyc, RUN_CYCLES);
      checkOutput({name, " busy at done"}, int'(busy), 0);
      checkOutput({name, " predicted_class"}, int'(predicted_class), expPred);
      checkOutput({name, " best_similarity"}, int'(best_similarity), expBest);
      @(posedge clk);
      #1;
      checkOutput({name, " done one cycle"}, int'(done), 0);
      checkOutput({name, " predicted held"}, int'(predicted_class), expPred);
      checkOutput({name, " best held"}, int'(best_similarity), expBest);
`ifdef AM_REJECT_EN
      checkOutput({name, " rejected"}, int'(rejected), expRej);
`else
      if (expRej < 0) $display("[TB] unexpected reject expectation in %s", name);
`endif
      @(posedge clk);
      #1;
      checkOutput({name, " compare cycles"}, compCnt - c0, CLASSES*CHUNKS);
      checkOutput({name, " infer cycles"}, infCnt - i0, CLASSES);
      checkOutput({name, " clear cycles"}, clearCnt - cl0, CLASSES);
      checkOutput({name, " done pulses"}, doneCnt - d0, 1);
      checkOutput({name, " busy cycles"}, busyCnt - b0, RUN_CYCLES-1);
      checkOutput({name, " and gating"}, andViol - a0, 0);
      checkOutput({name, " class runs"}, runQ.size() - r0, CLASSES);
      for (int c = 0; c < CLASSES; c++) begin
         checkOutput($sformatf("%s run class %0d", name, c), runQ[r0+c], CHUNKS);
      end
      checkOutput({name, " reads"}, addrQ.size() - ad0, CLASSES*CHUNKS);
      errs = 0;
      qErrs = 0;
      for (int i = 0; i < CLASSES*CHUNKS; i++) begin
         if (addrQ[ad0+i] != i) errs++;
         if (qAddrQ[ad0+i] != i % CHUNKS) qErrs++;
      end
      checkOutput({name, " cl addr seq errors"}, errs, 0);
      checkOutput({name, " q addr seq errors"}, qErrs, 0);
   endtask

   initial begin
      int doneCyc, d0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkResetValues("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Class 2 matches the query: 8 bits x 10 chunks = 80.
      loadVectors(16'h00FF, 16'h000F, 16'h007F, 16'h00FF, 16'hFF00);
      runAndCheck("match", 2, 80, 0, -1);

      // Every class equal to the query: tie keeps class 0.
      loadVectors(16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
      runAndCheck("tie", 0, 80, 0, -1);

      // Ascending overlap 10/20/30/40 with a stray start while busy.
      loadVectors(16'h00FF, 16'h0001, 16'h0003, 16'h0007, 16'h000F);
      runAndCheck("ascending", 3, 40, 0, 20);

      // Empty query: all similarities zero, below a threshold of 1.
      loadVectors(16'h0000, 16'hFFFF, 16'h00FF, 16'h1234, 16'hF0F0);
      runAndCheck("zero query", 0, 0, 1, -1);

      // Reset during class 1, chunk 5 (cycle 18): address 15 on the bus.
      loadVectors(16'h00FF, 16'h000F, 16'h007F, 16'h00FF, 16'hFF00);
      d0 = doneCnt;
      applyStimulus(-1, 18, doneCyc);
      checkOutput("abort cl_rd_addr", int'(cl_rd_addr), 15);
      checkOutput("abort q_rd_addr", int'(q_rd_addr), 5);
      checkOutput("abort best before reset", int'(best_similarity), 40);
      @(posedge clk);
      #1;
      checkResetValues("abort");
`ifdef AM_REJECT_EN
      checkOutput("abort rejected", int'(rejected), 0);
`endif
      rst = 1'b0;
      repeat (RUN_CYCLES + 10) @(posedge clk);
      #1;
      checkOutput("abort no done", doneCnt - d0, 0);
      checkOutput("abort idle busy", int'(busy), 0);
      runAndCheck("after abort", 2, 80, 0, -1);

      $display("%0d/%0d checks passed", passCnt, checkCnt);
      $finish;
   end

endmodule

// File: doc/am_query_streamer.md
AM_QUERY_STREAMER -- requirements
Module: am_query_streamer

Interface
REQ-001 SHALL have parameter DIMS_PER_CC, default 500, giving the hypervector bits per chunk (one chunk per cycle).
REQ-002 SHALL have parameter NUM_CHUNKS, default 10, giving the chunks per hypervector (5000 dims).
REQ-003 SHALL have parameter NUM_CLASSES, default 26, giving the class hypervectors in class memory.
REQ-004 SHALL have a single clock and a synchronous, active-high reset; clk and rst are the first two ports.
REQ-005 SHALL have port: clk  input  1  rising-edge clock.
REQ-006 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port: start  input  1  pulse that begins one inference.
REQ-008 SHALL have port: busy  output  1  high from the cycle after an accepted start until done.
REQ-009 SHALL have port: done  output  1  one-cycle pulse when the result is valid.
REQ-010 SHALL have port: q_rd_addr  output  $clog2(NUM_CHUNKS)  query memory chunk address.
REQ-011 SHALL have port: q_rd_data  input  DIMS_PER_CC  query chunk, valid the cycle after the address.
REQ-012 SHALL have port: cl_rd_addr  output  $clog2(NUM_CLASSES*NUM_CHUNKS)  class memory address, equal to class*NUM_CHUNKS+chunk.
REQ-013 SHALL have port: cl_rd_data  input  DIMS_PER_CC  class chunk, valid the cycle after the address.
REQ-014 SHALL have port: rd_en  output  1  read strobe common to both memories.
REQ-015 SHALL have port: and_array_out  output  DIMS_PER_CC  q_rd_data AND cl_rd_data, driven to the tree adder.
REQ-016 SHALL have port: comparing_query_hv_with_class_hv  output  1  adder accumulate enable.
REQ-017 SHALL have port: inferring_class  output  1  adder hold enable.
REQ-018 SHALL have port: similarity_value  input  13  registered adder result.
REQ-019 SHALL have port: predicted_class  output  $clog2(NUM_CLASSES)  argmax class index.
REQ-020 SHALL have port: best_similarity  output  13  similarity of predicted_class.

Function
REQ-021 SHALL implement the states IDLE, FETCH, COMPARE and DONE.
REQ-022 SHALL, in IDLE, accept start by loading class=0 and chunk=0 and entering FETCH; start is ignored in every other state.
REQ-023 SHALL, in FETCH, assert rd_en and issue chunk address k each cycle for k = 0..NUM_CHUNKS-1, then spend one extra FETCH cycle with no issue (rd_en=0) to drain the last read.
REQ-024 SHALL assert comparing_query_hv_with_class_hv exactly on the NUM_CHUNKS FETCH cycles whose read data is valid; it is low on the first issue cycle of each class, which clears the adder.
REQ-025 SHALL hold and_array_out at 0 whenever comparing_query_hv_with_class_hv is low.
REQ-026 SHALL spend one cycle in COMPARE per class with inferring_class=1, comparing_query_hv_with_class_hv=0 and rd_en=0; this gives NUM_CHUNKS+2 cycles per class.
REQ-027 SHALL, in COMPARE for class 0, load best_similarity and predicted_class unconditionally.
REQ-028 SHALL, in COMPARE for class c>0, update best_similarity and predicted_class only if similarity_value > best_similarity; on a tie the lower index is kept.
REQ-029 SHALL, from COMPARE, go to FETCH with class+1 and chunk=0 if class < NUM_CLASSES-1; otherwise it goes to DONE.
REQ-030 SHALL, in DONE, pulse done for one cycle, drop busy and return to IDLE.
REQ-031 SHALL hold predicted_class and best_similarity from DONE until the next COMPARE of class 0.
REQ-032 SHALL assert done exactly NUM_CLASSES*(NUM_CHUNKS+2)+1 cycles after the start-accept cycle.
REQ-033 SHALL keep inferring_class low outside COMPARE.
REQ-034 SHALL keep comparing_query_hv_with_class_hv low in IDLE and DONE, so the adder clears there.

Reset
REQ-035 SHALL, with rst high at a clock edge, force: state=IDLE, busy=0, done=0, rd_en=0, both addresses=0, and_array_out=0, comparing_query_hv_with_class_hv=0, inferring_class=0, predicted_class=0, best_similarity=0.
REQ-036 SHALL let rst mid-inference abort the run without a done pulse; the next start runs a complete fresh inference.

Configuration
REQ-037 SHALL, with macro AM_REJECT_EN defined, add input reject_threshold[12:0] and output rejected (1 bit); rejected is registered in DONE as best_similarity < reject_threshold and reset to 0.
REQ-038 SHALL, without AM_REJECT_EN, have neither of these ports and no related logic; all other behaviour is identical.

Verification
REQ-039 SHALL cover: NUM_CLASSES=4, NUM_CHUNKS=10, class 2 equal to the query, others random -> predicted_class=2, best_similarity=query popcount, done at cycle 49 after start.
REQ-040 SHALL cover: all classes identical -> predicted_class=0 (tie rule).
REQ-041 SHALL cover: all-zero query -> best_similarity=0, predicted_class=0; with AM_REJECT_EN and threshold=1, rejected=1.
REQ-042 SHALL cover: start pulsed again while busy -> ignored, single done, cl_rd_addr sequence 0..39 unchanged.
REQ-043 SHALL cover: rst asserted in class 1 chunk 5 -> all outputs at reset values the next cycle, no done; a new start -> correct result.
REQ-044 SHALL cover: cycle check per class -> comparing_query_hv_with_class_hv high for exactly 10 cycles, inferring_class high for 1, and one adder-clear cycle before each class.
